// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI memory arbiter.
// The request struct width tracks OBI_ADDR_W/OBI_DATA_W; the top defaults to the same widths.
package obi_arb_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0]   addr;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_DATA_W-1:0]   wdata;
    } obi_req_t;

    // Requester index width; never below one bit so two requesters still get a real index.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester indices, one entry per accepted transfer awaiting a response.
// Push is ignored while full and pop while empty, so callers need not gate them.
module obi_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt == CW'(DEPTH));
    assign empty_o = (cnt == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (do_pop && !do_push) cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin OBI arbiter sharing one memory port between NUM_REQ requesters.
// A stalled request stays locked to its winner; an ID FIFO routes responses back in issue order.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = OBI_ADDR_W,
    parameter int DATA_WIDTH      = OBI_DATA_W,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            mem_req_o,
    input  logic                            mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic                            mem_we_o,
    output logic [DATA_WIDTH/8-1:0]         mem_be_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o,
    input  logic                            mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
    output logic                            err_o
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = DATA_WIDTH / 8;

    obi_req_t [NUM_REQ-1:0] reqs;
    obi_req_t               sel;

    logic [IW-1:0] ptr, lock_idx, winner, sel_idx, ptr_nxt, head;
    logic          locked, req_any, accept, pop, fifo_full, fifo_empty;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign reqs[g].addr  = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign reqs[g].we    = we_i[g];
        assign reqs[g].be    = be_i[g*BW +: BW];
        assign reqs[g].wdata = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the far end toward ptr so the nearest requester at or after ptr wins.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IW-1:0] p);
        logic [IW-1:0] pick;
        int            idx;
        pick = p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (req[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    assign winner  = locked ? lock_idx : rr_pick(req_i, ptr);
    // A locked requester that drops req_i issues nothing; the lock clears at the edge.
    assign req_any = locked ? req_i[lock_idx] : |req_i;
    assign mem_req_o = req_any & ~fifo_full & ~rst_i;
    assign accept    = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~fifo_empty;
    assign ptr_nxt   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + IW'(1);

    assign sel_idx     = mem_req_o ? winner : '0;
    assign sel         = reqs[sel_idx];
    assign mem_addr_o  = sel.addr;
    assign mem_we_o    = sel.we;
    assign mem_be_o    = sel.be;
    assign mem_wdata_o = sel.wdata;

    assign rdata_o = mem_rdata_i;
    assign err_o   = mem_rvalid_i & fifo_empty & ~rst_i;

    always_comb begin
        gnt_o         = '0;
        gnt_o[winner] = accept;
        rvalid_o       = '0;
        rvalid_o[head] = pop & ~rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr      <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (accept) ptr <= ptr_nxt;
            if (accept) begin
                locked <= 1'b0;
            end else if (mem_req_o) begin
                locked   <= 1'b1;
                lock_idx <= winner;
            end else if (locked && !req_i[lock_idx]) begin
                locked <= 1'b0;
            end
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (winner),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter: two requesters, two outstanding transfers.
module tb_obi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, gnt, rvalid, we;
    logic [63:0] addr, wdata;
    logic [7:0]  be;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid, err;
    logic [3:0]  mem_be;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .gnt_o        (gnt),
        .addr_i       (addr),
        .we_i         (we),
        .be_i         (be),
        .wdata_i      (wdata),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .err_o        (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are checked 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic g, input logic rv);
        req        = r;
        mem_gnt    = g;
        mem_rvalid = rv;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        addr = {32'h0000_2000, 32'h0000_1000};
        we = 2'b00; be = 8'hFF; wdata = {32'h2222_2222, 32'h1111_1111};
        mem_rdata = 32'h0;
        drive(2'b11, 1'b1, 1'b1);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_err", err, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // single requester read
        addr[63:32] = 32'h8000_0004;
        drive(2'b10, 1'b1, 1'b0);
        chk("s_mem_req", mem_req, 1'b1);
        chk("s_addr", mem_addr, 32'h8000_0004);
        chk("s_we", mem_we, 1'b0);
        chk("s_gnt", gnt, 2'b10);
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        drive(2'b00, 1'b0, 1'b1);
        chk("s_rvalid", rvalid, 2'b10);
        chk("s_rdata", rdata, 32'hDEAD_BEEF);
        chk("s_err", err, 1'b0);
        tick();
        addr[63:32] = 32'h0000_2000;

        // contention with one-cycle response latency; ptr is back at 0
        drive(2'b11, 1'b1, 1'b0);
        chk("c_gnt0", gnt, 2'b01);
        tick();
        drive(2'b11, 1'b1, 1'b1);
        chk("c_gnt1", gnt, 2'b10);
        chk("c_rv1", rvalid, 2'b01);
        tick();
        chk("c_gnt2", gnt, 2'b01);
        chk("c_rv2", rvalid, 2'b10);
        tick();
        chk("c_gnt3", gnt, 2'b10);
        chk("c_rv3", rvalid, 2'b01);
        tick();
        drive(2'b00, 1'b0, 1'b1);
        chk("c_rv4", rvalid, 2'b10);
        tick();

        // stall lock on requester 0
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 1'b0, 1'b0);
            chk("l_addr", mem_addr, 32'h0000_1000);
            chk("l_gnt", gnt, 2'b00);
            tick();
        end
        drive(2'b11, 1'b0, 1'b0);
        chk("l_addr_both", mem_addr, 32'h0000_1000);
        tick();
        drive(2'b11, 1'b1, 1'b0);
        chk("l_gnt_first", gnt, 2'b01);
        tick();
        drive(2'b11, 1'b1, 1'b1);
        chk("l_gnt_next", gnt, 2'b10);
        chk("l_rv0", rvalid, 2'b01);
        tick();
        drive(2'b00, 1'b0, 1'b1);
        chk("l_rv1", rvalid, 2'b10);
        tick();

        // lock on requester 1 overrides ptr=0; a dropped request clears the lock
        drive(2'b10, 1'b0, 1'b0);
        chk("k_addr1", mem_addr, 32'h0000_2000);
        tick();
        drive(2'b11, 1'b0, 1'b0);
        chk("k_addr_hold", mem_addr, 32'h0000_2000);
        tick();
        drive(2'b01, 1'b0, 1'b0);
        chk("k_drop_req", mem_req, 1'b0);
        tick();
        drive(2'b01, 1'b1, 1'b0);
        chk("k_addr0", mem_addr, 32'h0000_1000);
        chk("k_gnt0", gnt, 2'b01);
        tick();
        drive(2'b00, 1'b0, 1'b1);
        chk("k_rv0", rvalid, 2'b01);
        tick();

        // full FIFO: ptr=1 now
        drive(2'b11, 1'b1, 1'b0);
        chk("f_gnt_a", gnt, 2'b10);
        tick();
        chk("f_gnt_b", gnt, 2'b01);
        tick();
        chk("f_full_req", mem_req, 1'b0);
        chk("f_full_gnt", gnt, 2'b00);
        tick();
        drive(2'b11, 1'b1, 1'b1);
        chk("f_pop_req", mem_req, 1'b0);
        chk("f_rv_a", rvalid, 2'b10);
        tick();
        drive(2'b11, 1'b1, 1'b0);
        chk("f_resume_req", mem_req, 1'b1);
        chk("f_resume_gnt", gnt, 2'b10);
        tick();
        drive(2'b00, 1'b0, 1'b1);
        chk("f_rv_b", rvalid, 2'b01);
        tick();
        chk("f_rv_c", rvalid, 2'b10);
        tick();

        // spurious response
        drive(2'b00, 1'b0, 1'b1);
        chk("e_err", err, 1'b1);
        chk("e_rvalid", rvalid, 2'b00);
        tick();
        drive(2'b00, 1'b0, 1'b0);
        chk("e_err_low", err, 1'b0);

        // mid-operation reset with two outstanding, ptr left at 1
        drive(2'b10, 1'b1, 1'b0);
        chk("r_gnt1", gnt, 2'b10);
        tick();
        drive(2'b01, 1'b1, 1'b0);
        chk("r_gnt0", gnt, 2'b01);
        tick();
        rst = 1'b1;
        drive(2'b11, 1'b1, 1'b0);
        chk("r_rst_req", mem_req, 1'b0);
        chk("r_rst_gnt", gnt, 2'b00);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(2'b00, 1'b0, 1'b1);
            chk("r_err", err, 1'b1);
            chk("r_rvalid", rvalid, 2'b00);
            tick();
        end
        drive(2'b11, 1'b1, 1'b0);
        chk("r_next_gnt", gnt, 2'b01);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
